// File: rtl/vend_controller.sv
// vend_controller: coin-credit vending sequencer with dispense handshake and 5-unit change return
module vend_controller #(
    parameter int PRICE_A    = 15,
    parameter int PRICE_B    = 20,
    parameter int MAX_CREDIT = 35,
    parameter int TIMEOUT    = 255,
    parameter int CREDIT_W   = 6
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [1:0]          coin,
    input  logic [1:0]          sel,
    input  logic                cancel,
    input  logic                disp_ack,
    output logic                disp_req,
    output logic                disp_item,
    output logic                change_pulse,
    output logic                coin_reject,
    output logic                short_credit,
    output logic [CREDIT_W-1:0] credit,
    output logic [1:0]          state
);
    typedef enum logic [1:0] {IDLE = 2'b00, COLLECT = 2'b01, VEND = 2'b10, CHANGE = 2'b11} state_t;

    localparam int TW  = $clog2(TIMEOUT + 1);
    localparam int CW1 = CREDIT_W + 1;
    localparam logic [CREDIT_W-1:0] PA   = CREDIT_W'(PRICE_A);
    localparam logic [CREDIT_W-1:0] PB   = CREDIT_W'(PRICE_B);
    localparam logic [CREDIT_W-1:0] FIVE = CREDIT_W'(5);
    localparam logic [CREDIT_W-1:0] TEN  = CREDIT_W'(10);
    localparam logic [CREDIT_W:0]   MAXC = CW1'(MAX_CREDIT);
    localparam logic [TW-1:0]       T_LAST = TW'(TIMEOUT - 1);

    state_t              st;
    logic [TW-1:0]       idle_cnt;
    logic [CREDIT_W-1:0] coin_val, coin_add, price;
    logic                coin_ok, sel_valid, sel_fund;

    assign state = st;

    // qualify the coin and selection against the credit held at the start of the cycle
    always_comb begin
        coin_val  = coin == 2'b01 ? FIVE : coin == 2'b10 ? TEN : '0;
        coin_ok   = (st == IDLE || st == COLLECT) && coin_val != '0 && !cancel &&
                    ({1'b0, credit} + {1'b0, coin_val}) <= MAXC;
        coin_add  = coin_ok ? coin_val : '0;
        sel_valid = sel == 2'b01 || sel == 2'b10;
        price     = sel[1] ? PB : PA;
        sel_fund  = sel_valid && credit >= price;
    end

    // transaction sequencer: all outputs are registered responses to the sampled inputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            st           <= IDLE;
            credit       <= '0;
            idle_cnt     <= '0;
            disp_req     <= 1'b0;
            disp_item    <= 1'b0;
            change_pulse <= 1'b0;
            coin_reject  <= 1'b0;
            short_credit <= 1'b0;
        end else begin
            coin_reject  <= coin != 2'b00 && !coin_ok;
            short_credit <= 1'b0;
            change_pulse <= 1'b0;
            case (st)
                IDLE: begin
                    if (coin_ok) begin
                        credit   <= credit + coin_add;
                        idle_cnt <= '0;
                        st       <= COLLECT;
                    end
                end
                COLLECT: begin
                    if (cancel) begin
                        idle_cnt <= '0;
                        st       <= CHANGE;
                    end else begin
                        credit       <= credit - (sel_fund ? price : '0) + coin_add;
                        short_credit <= sel_valid && !sel_fund;
                        idle_cnt     <= (sel_valid || coin_ok || idle_cnt == T_LAST) ? '0 : idle_cnt + 1'b1;
                        if (sel_fund) begin
                            disp_req  <= 1'b1;
                            disp_item <= sel[1];
                            st        <= VEND;
                        end else if (!sel_valid && !coin_ok && idle_cnt == T_LAST) begin
                            st <= CHANGE;
                        end
                    end
                end
                VEND: begin
                    if (disp_ack) begin
                        disp_req <= 1'b0;
                        st       <= credit != '0 ? CHANGE : IDLE;
                    end
                end
                CHANGE: begin
                    if (credit == '0) begin
                        st <= IDLE;
                    end else if (!change_pulse) begin
                        change_pulse <= 1'b1;
                        credit       <= credit - FIVE;
                        if (credit == FIVE) st <= IDLE;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_vend_controller.sv
// tb_vend_controller: randomized scoreboard bench for the vending sequencer
module tb_vend_controller;
    localparam int PRICE_A    = 15;
    localparam int PRICE_B    = 20;
    localparam int MAX_CREDIT = 35;
    localparam int TIMEOUT    = 255;
    localparam int CREDIT_W   = 6;

    typedef struct packed {
        logic [1:0] st;
        logic [5:0] cr;
        logic       req;
        logic       item;
        logic       pulse;
        logic       rej;
        logic       sc;
    } obs_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] coin = 2'b00;
    logic [1:0] sel = 2'b00;
    logic       cancel = 1'b0;
    logic       disp_ack = 1'b0;
    logic       disp_req, disp_item, change_pulse, coin_reject, short_credit;
    logic [CREDIT_W-1:0] credit;
    logic [1:0] state;

    int   tests = 0;
    int   fails = 0;
    obs_t q[$];
    obs_t e, act;

    int m_state, m_credit, m_idle;
    bit m_req, m_item, m_pulse, m_rej, m_sc;

    vend_controller #(
        .PRICE_A(PRICE_A), .PRICE_B(PRICE_B), .MAX_CREDIT(MAX_CREDIT),
        .TIMEOUT(TIMEOUT), .CREDIT_W(CREDIT_W)
    ) dut (
        .clk(clk), .reset(reset), .coin(coin), .sel(sel), .cancel(cancel),
        .disp_ack(disp_ack), .disp_req(disp_req), .disp_item(disp_item),
        .change_pulse(change_pulse), .coin_reject(coin_reject),
        .short_credit(short_credit), .credit(credit), .state(state)
    );

    always #5 clk = ~clk;

    // reference: one cycle of the vending rules in plain integer arithmetic
    task automatic model(input int c, input int s, input bit x, input bit a);
        int  val, price;
        bit  acc, sv, prev;
        val   = c == 1 ? 5 : c == 2 ? 10 : 0;
        acc   = m_state <= 1 && val > 0 && !x && m_credit + val <= MAX_CREDIT;
        prev  = m_pulse;
        m_pulse = 0;
        m_sc  = 0;
        m_rej = c != 0 && !acc;
        if (m_state == 0) begin
            if (acc) begin
                m_credit += val;
                m_state = 1;
                m_idle = 0;
            end
        end else if (m_state == 1) begin
            if (x) begin
                m_state = 3;
                m_idle = 0;
            end else begin
                sv    = s == 1 || s == 2;
                price = s == 2 ? PRICE_B : PRICE_A;
                if (sv && m_credit >= price) begin
                    m_credit -= price;
                    m_state = 2;
                    m_req = 1;
                    m_item = s == 2;
                end else if (sv) begin
                    m_sc = 1;
                end
                if (acc) m_credit += val;
                if (sv || acc) m_idle = 0;
                else begin
                    m_idle++;
                    if (m_idle == TIMEOUT) begin
                        m_state = 3;
                        m_idle = 0;
                    end
                end
            end
        end else if (m_state == 2) begin
            if (a) begin
                m_req = 0;
                m_state = m_credit > 0 ? 3 : 0;
            end
        end else begin
            if (m_credit == 0) m_state = 0;
            else if (!prev) begin
                m_pulse = 1;
                m_credit -= 5;
                if (m_credit == 0) m_state = 0;
            end
        end
        q.push_back('{2'(m_state), 6'(m_credit), m_req, m_req & m_item, m_pulse, m_rej, m_sc});
    endtask

    task automatic cyc(input int c = 0, input int s = 0, input int x = 0, input int a = 0);
        @(negedge clk);
        coin     = 2'(c);
        sel      = 2'(s);
        cancel   = x != 0;
        disp_ack = a != 0;
        model(c, s, x != 0, a != 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        coin = 2'b01;
        sel = 2'b00;
        cancel = 1'b0;
        disp_ack = 1'b0;
        #2 reset = 1'b0;
        m_state = 0; m_credit = 0; m_idle = 0;
        m_req = 0; m_item = 0; m_pulse = 0; m_rej = 0; m_sc = 0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        coin = 2'b00;
        model(0, 0, 1'b0, 1'b0);
    endtask

    // monitor: reset must clear outputs at once; otherwise every edge is checked against the queue
    always @(posedge clk or negedge reset) begin
        #1;
        act = '{state, credit, disp_req, disp_req & disp_item, change_pulse, coin_reject, short_credit};
        if (!reset) begin
            tests++;
            if (act !== '0 || disp_item !== 1'b0) begin
                fails++;
                $display("FAIL reset t=%0t got st=%0d cr=%0d req=%0b item=%0b pulse=%0b rej=%0b sc=%0b, expected all zero",
                         $time, state, credit, disp_req, disp_item, change_pulse, coin_reject, short_credit);
            end
        end else if (q.size() != 0) begin
            e = q.pop_front();
            tests++;
            if (act !== e) begin
                fails++;
                $display("FAIL cycle t=%0t got st=%0d cr=%0d req=%0b item=%0b pulse=%0b rej=%0b sc=%0b, expected st=%0d cr=%0d req=%0b item=%0b pulse=%0b rej=%0b sc=%0b",
                         $time, act.st, act.cr, act.req, act.item, act.pulse, act.rej, act.sc,
                         e.st, e.cr, e.req, e.item, e.pulse, e.rej, e.sc);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog t=%0t run did not complete", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        m_state = 0; m_credit = 0; m_idle = 0;
        m_req = 0; m_item = 0; m_pulse = 0; m_rej = 0; m_sc = 0;
        #2 reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        model(0, 0, 1'b0, 1'b0);
        cyc(1);
        cyc(2);
        do_reset();
        cyc(1);
        cyc();
        do_reset();
        cyc(2); cyc(1); cyc(0, 1);
        cyc(); cyc(); cyc(); cyc(0, 0, 0, 1); cyc(); cyc();
        cyc(2); cyc(2); cyc(2); cyc(0, 2);
        cyc(); cyc(0, 0, 0, 1);
        repeat (6) cyc();
        cyc(3);
        cyc(2); cyc(2); cyc(2); cyc(2); cyc(1);
        cyc(0, 0, 1);
        repeat (20) cyc();
        cyc(2); cyc(0, 2);
        cyc(1, 1);
        cyc(2, 0, 1);
        repeat (8) cyc();
        cyc(1);
        repeat (TIMEOUT + 4) cyc();
        cyc(1);
        repeat (TIMEOUT - 1) cyc();
        cyc(1);
        repeat (TIMEOUT + 4) cyc();
        for (int i = 0; i < 3000; i++) begin
            int c, s, x, a;
            c = $urandom_range(0, 9) < 3 ? int'($urandom_range(1, 3)) : 0;
            s = $urandom_range(0, 9) < 1 ? int'($urandom_range(1, 3)) : 0;
            x = $urandom_range(0, 49) == 0 ? 1 : 0;
            a = m_req ? ($urandom_range(0, 2) == 0 ? 1 : 0) : ($urandom_range(0, 19) == 0 ? 1 : 0);
            cyc(c, s, x, a);
            if ($urandom_range(0, 499) == 0) repeat (TIMEOUT + 2) cyc();
            if ($urandom_range(0, 299) == 0) do_reset();
        end
        cyc();
        @(negedge clk);
        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
